// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - Oversampling UART receiver with majority vote, parity, framing and break detection
module uart_rx_os #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 busy
);

   localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW       = $clog2(OVERSAMPLE);

   localparam logic [TW-1:0] T_MAX     = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SMP_LO    = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SMP_MID   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] SMP_HI    = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] SMP_MAX   = SW'(OVERSAMPLE - 1);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic          ODD_MODE  = (PARITY == 1);

   if (TICK_DIV < 1) begin : g_tick_div_check
      $error("uart_rx_os: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state, state_n;
   logic                 rx_meta, rx_s;
   logic [TW-1:0]        tick_cnt;
   logic [SW-1:0]        s;
   logic                 tick, decide, start_det;
   logic                 samp_a, samp_b, vote;
   logic [DATA_BITS-1:0] shreg;
   logic [3:0]           bit_cnt;
   logic                 par_flag, frm_flag, seen_one;
   logic                 par_bad, brk_now, last_stop_dec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign start_det = (state == S_IDLE) && !rx_s;
   assign tick      = (tick_cnt == T_MAX);
   assign decide    = tick && (s == SMP_HI);

   // Restarting the tick and sample counters at the start edge centres the votes on each bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         s        <= '0;
      end else if (start_det) begin
         tick_cnt <= '0;
         s        <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick) s <= (s == SMP_MAX) ? '0 : s + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         if (tick && (s == SMP_LO))  samp_a <= rx_s;
         if (tick && (s == SMP_MID)) samp_b <= rx_s;
      end
   end

   assign vote          = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
   assign par_bad       = ((^shreg) ^ vote) != ODD_MODE;
   assign brk_now       = !seen_one && !vote;
   assign last_stop_dec = (state == S_STOP) && decide && (bit_cnt == LAST_STOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (!rx_s) state_n = S_START;
         S_START:  if (decide) state_n = vote ? S_IDLE : S_DATA;
         S_DATA:   if (decide && (bit_cnt == LAST_DATA))
                      state_n = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (decide) state_n = S_STOP;
         S_STOP:   if (last_stop_dec) state_n = brk_now ? S_BREAK : S_IDLE;
         S_BREAK:  if (rx_s) state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // seen_one tracks whether any data, parity or stop bit was voted 1, which rules out a break.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         par_flag <= 1'b0;
         frm_flag <= 1'b0;
         seen_one <= 1'b0;
      end else if (start_det) begin
         bit_cnt  <= '0;
         par_flag <= 1'b0;
         frm_flag <= 1'b0;
         seen_one <= 1'b0;
      end else if (decide) begin
         case (state)
            S_DATA: begin
               shreg    <= {vote, shreg[DATA_BITS-1:1]};
               seen_one <= seen_one | vote;
               bit_cnt  <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
            end
            S_PARITY: begin
               seen_one <= seen_one | vote;
               if (par_bad) par_flag <= 1'b1;
            end
            S_STOP: begin
               seen_one <= seen_one | vote;
               if (!vote) frm_flag <= 1'b1;
               bit_cnt  <= (bit_cnt == LAST_STOP) ? '0 : bit_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
         if (last_stop_dec) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
            parity_err <= par_flag;
            frame_err  <= frm_flag | !vote;
            break_det  <= brk_now;
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver: the next-generation receive path of the serial link blocks. It supports configurable data width, parity mode, stop-bit count and oversampling ratio, and takes a 3-sample majority vote at mid-bit. It rejects start-bit glitches and reports parity, framing and break conditions alongside each received character. It sits between the asynchronous `rx` pin and the byte-oriented consumer logic; there is no backpressure, and the consumer must take each character in its `data_valid` cycle.

## Interface

Parameters:
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line bit rate.
- `OVERSAMPLE`, default 16: ticks per bit, even, minimum 8.
- `DATA_BITS`, default 8: data bits per frame, 5 to 9, sent LSB first.
- `PARITY`, default 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `TICK_DIV` (localparam) = `CLK_FREQ/(BAUD_RATE*OVERSAMPLE)`: clocks per tick. It must be at least 1; elaboration fails otherwise.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `rx`, input, 1: serial line, asynchronous, idle high.
- `data_out`, output, `DATA_BITS`: last received character.
- `data_valid`, output, 1: one-cycle strobe marking a completed frame.
- `parity_err`, output, 1: parity mismatch; meaningful only when `data_valid`=1.
- `frame_err`, output, 1: a stop bit was sampled 0; meaningful only when `data_valid`=1.
- `break_det`, output, 1: break condition; meaningful only when `data_valid`=1.
- `busy`, output, 1: high while a frame is being received or a break is in progress.

## Operation

- **Input synchroniser.** `rx` passes through 2 flops, which reset to 1; all logic uses the synchronised value `rx_s`.
- **Tick generator.** The tick counter counts 0..`TICK_DIV`-1 and emits a one-clock `tick` on wrap. It is cleared on start detection.
- **Sample counter.** `s` runs 0..`OVERSAMPLE`-1 and advances on each tick; it wraps at the bit boundary.
- **Sampling.** `rx_s` is captured at `s` = `OVERSAMPLE`/2-1, `OVERSAMPLE`/2 and `OVERSAMPLE`/2+1. The bit value is the majority of the 3 samples and is decided on the tick at `s` = `OVERSAMPLE`/2+1.
- **States:**
  - IDLE: when `rx_s`=0, clear the tick counter and `s`, set `busy`, go to START.
  - START: if the voted bit is 1, treat it as a glitch: return to IDLE, clear `busy`, no strobe. If 0, go to DATA.
  - DATA: shift in `DATA_BITS` voted bits, LSB first. Then go to PARITY if `PARITY`≠0, else STOP.
  - PARITY: compare the voted bit with the XOR of the data bits. Odd mode expects XOR(data, parity)=1; even mode expects 0. A mismatch latches the internal parity flag.
  - STOP: vote `STOP_BITS` bits; any 0 latches the internal frame flag. At the decision tick of the last stop bit, in the same clock:
    - load `data_out`, pulse `data_valid`, and drive the flags;
    - if no break, go to IDLE and clear `busy`.
  - BREAK_WAIT: entered in place of IDLE when the break condition holds. Stay while `rx_s`=0, with `busy` held at 1. Go to IDLE on the first `rx_s`=1.
- **Break condition.** All data bits 0, the parity bit (if present) 0, and every stop bit 0. In that case `break_det`=1 and `frame_err`=1 in the strobe cycle, and `data_out` is all zeros.
- **Back-to-back frames.** Because IDLE is re-entered at mid stop bit, a start edge arriving half a bit later is accepted without loss.
- **Output hold rules.**
  - `data_out` holds its value between strobes.
  - `parity_err`, `frame_err` and `break_det` are 0 in every cycle where `data_valid`=0.
  - The internal error flags clear on entering START.

## Timing

- **Reset values.** While `rst_n`=0 and immediately after release:
  - `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, `busy`=0;
  - state IDLE;
  - synchroniser flops at 1.
- **Reset mid-frame.** Asynchronous assertion aborts the frame immediately; no strobe is produced.
- **Start detection.** IDLE sees the `rx` falling edge 2 clocks after it appears at the pin, plus 1 clock to register.
- **Strobe latency.** From entry to START, `data_valid` follows after N×`OVERSAMPLE`×`TICK_DIV` − (`OVERSAMPLE`/2−2)×`TICK_DIV` clocks ±1, where N = 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`.
- **Strobe width.** `data_valid` is exactly 1 clock and is never asserted on consecutive clocks.
- **`busy` timing.** `busy` rises the clock after start detection. It falls in the strobe cycle, the glitch-reject cycle, or the BREAK_WAIT exit cycle.
- **Glitch rejection.** Any low pulse shorter than (`OVERSAMPLE`/2−1) ticks is rejected.

## Test plan

Bench parameters: `CLK_FREQ`=1600000, `BAUD_RATE`=100000, `OVERSAMPLE`=16, giving `TICK_DIV`=1 and 16 clocks per bit.

- **8N1 frame.** Drive 0xA5 → one `data_valid` pulse with `data_out`=0xA5 and all error flags 0; `busy` low afterwards.
- **8E1 with bad parity.** `PARITY`=2; send 0x0F with parity bit 1 → `data_out`=0x0F, `parity_err`=1, `frame_err`=0. Resend with parity bit 0 → `parity_err`=0.
- **Stop bit held low.** 8N1, send 0x3C with its stop bit 0 → `data_out`=0x3C, `frame_err`=1, `break_det`=0.
- **Start glitch.** `rx` low for 4 clocks then high → no `data_valid`; `busy` returns to 0 within 16 clocks. A following valid 0x5A frame is received correctly.
- **Break.** `rx` low for 20 bit times → a single strobe with `data_out`=0x00, `frame_err`=1, `break_det`=1. `busy` stays 1 until `rx` returns high, and no second strobe occurs.
- **Back-to-back and reset.**
  - 0x55 then 0xAA with no idle gap → two strobes, 10 bit times apart, with correct data.
  - Assert `rst_n` mid-frame → all outputs 0. Then send 0x81 → received cleanly.
  - Repeat with `DATA_BITS`=9, `STOP_BITS`=2, sending 0x1FF → `data_out`=0x1FF.
